phy_tx_sched: RTL

PHY_TX_SCHED -- requirements
Module: phy_tx_sched

---
 rtl/phy_tx_sched.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/phy_tx_sched.sv
// PHY transmit scheduler: COM training burst, round-robin payload arbitration, idle fill.
// Defining PHY_TX_SKP_INSERT_EN compiles in periodic SKP word insertion.
module phy_tx_sched #(
  parameter int TRAIN_WORDS  = 16,
  parameter int SKP_INTERVAL = 64
) (
  input  logic        clk_f,
  input  logic        reset,
  input  logic        link_en,
  input  logic [31:0] req0_data,
  input  logic [31:0] req1_data,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic [1:0]  grant,
  output logic [1:0]  state_out
);

  localparam logic [31:0] WORD_TRAIN = 32'hBCBC_BCBC;
  localparam logic [31:0] WORD_IDLE  = 32'h7C7C_7C7C;
  localparam logic [7:0]  TRAIN_LAST = 8'(TRAIN_WORDS - 1);

  if ((TRAIN_WORDS < 1) || (TRAIN_WORDS > 255)) begin : g_bad_train
    $error("phy_tx_sched: TRAIN_WORDS out of range 1..255");
  end
  if ((SKP_INTERVAL < 2) || (SKP_INTERVAL > 1023)) begin : g_bad_skp
    $error("phy_tx_sched: SKP_INTERVAL out of range 2..1023");
  end

`ifdef PHY_TX_SKP_INSERT_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_SKP    = 2'd3
  } state_t;
  localparam logic [31:0] WORD_SKP = 32'h1C1C_1C1C;
  localparam logic [9:0]  SKP_LAST = 10'(SKP_INTERVAL - 1);
  logic [9:0] skp_cnt_r;
  logic [9:0] skp_cnt_nxt_s;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;
`endif

  state_t      state_r, state_nxt_s;
  logic [7:0]  train_cnt_r, train_cnt_nxt_s;
  logic        last_r, last_nxt_s;     // 1: req1 was granted last, so req0 wins a tie
  logic [31:0] data_r, data_nxt_s;
  logic        valid_r, valid_nxt_s;
  logic        skp_due_s;
  logic        active_ok_s;
  logic        pick1_s;
  logic        acc0_s, acc1_s;

`ifdef PHY_TX_SKP_INSERT_EN
  assign skp_due_s = (state_r == ST_ACTIVE) && (skp_cnt_r == SKP_LAST);
`else
  assign skp_due_s = 1'b0;
`endif

  // Round-robin arbitration producing the combinational readies
  always_comb begin
    active_ok_s = link_en && (state_r == ST_ACTIVE) && !skp_due_s;
    pick1_s     = req1_valid && (!req0_valid || !last_r);
    acc1_s      = active_ok_s && pick1_s;
    acc0_s      = active_ok_s && req0_valid && !pick1_s;
  end

  assign req0_ready = acc0_s;
  assign req1_ready = acc1_s;
  assign grant      = {acc1_s, acc0_s};
  assign data_out   = data_r;
  assign valid_out  = valid_r;
  assign state_out  = state_r;

  // Next-state, counter and next-output-word decode
  always_comb begin
    state_nxt_s     = ST_IDLE;
    train_cnt_nxt_s = 8'd0;
    data_nxt_s      = 32'h0000_0000;
    valid_nxt_s     = 1'b0;
    last_nxt_s      = last_r;
`ifdef PHY_TX_SKP_INSERT_EN
    skp_cnt_nxt_s   = 10'd0;
`endif
    if (!link_en) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_TRAIN;
          data_nxt_s  = WORD_TRAIN;
          valid_nxt_s = 1'b1;
        end
        ST_TRAIN: begin
          if (train_cnt_r == TRAIN_LAST) begin
            state_nxt_s = ST_ACTIVE;
            data_nxt_s  = WORD_IDLE;
            valid_nxt_s = 1'b0;
          end else begin
            state_nxt_s     = ST_TRAIN;
            train_cnt_nxt_s = train_cnt_r + 8'd1;
            data_nxt_s      = WORD_TRAIN;
            valid_nxt_s     = 1'b1;
          end
        end
        ST_ACTIVE: begin
          state_nxt_s = ST_ACTIVE;
          if (acc0_s) begin
            data_nxt_s  = req0_data;
            valid_nxt_s = 1'b1;
            last_nxt_s  = 1'b0;
          end else if (acc1_s) begin
            data_nxt_s  = req1_data;
            valid_nxt_s = 1'b1;
            last_nxt_s  = 1'b1;
          end else begin
            data_nxt_s  = WORD_IDLE;
            valid_nxt_s = 1'b0;
          end
`ifdef PHY_TX_SKP_INSERT_EN
          // SKP-due cycles never accept, so overriding the word loses nothing
          if (skp_due_s) begin
            state_nxt_s = ST_SKP;
            data_nxt_s  = WORD_SKP;
            valid_nxt_s = 1'b1;
          end else begin
            skp_cnt_nxt_s = skp_cnt_r + 10'd1;
          end
`endif
        end
`ifdef PHY_TX_SKP_INSERT_EN
        ST_SKP: begin
          state_nxt_s = ST_ACTIVE;
          data_nxt_s  = WORD_IDLE;
          valid_nxt_s = 1'b0;
        end
`endif
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters, arbitration pointer and registered output word
  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      train_cnt_r <= 8'd0;
      last_r      <= 1'b1;
      data_r      <= 32'h0000_0000;
      valid_r     <= 1'b0;
`ifdef PHY_TX_SKP_INSERT_EN
      skp_cnt_r   <= 10'd0;
`endif
    end else begin
      state_r     <= state_nxt_s;
      train_cnt_r <= train_cnt_nxt_s;
      last_r      <= last_nxt_s;
      data_r      <= data_nxt_s;
      valid_r     <= valid_nxt_s;
`ifdef PHY_TX_SKP_INSERT_EN
      skp_cnt_r   <= skp_cnt_nxt_s;
`endif
    end
  end

endmodule
